line_mem_responder: RTL and testbench
=====================================

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 The module SHALL take parameter LATENCY, default 4: number of BUSY cycles per access; legal range 1..15.
REQ-002 The module SHALL take parameter MEM_AW, default 14: number of low addr bits used to index storage (2^MEM_AW lines of 64 bits).
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port addr, input, 14 bits: line address of the request.
REQ-006 The module SHALL have port re, input, 1 bit: read request, level, held by initiator until rdy.
REQ-007 The module SHALL have port we, input, 1 bit: write request, level, held by initiator until rdy.
REQ-008 The module SHALL have port wdata, input, 64 bits: line write data.
REQ-009 The module SHALL have port rd_data, output, 64 bits: registered line read data.
REQ-010 The module SHALL have port rdy, output, 1 bit: one-cycle completion strobe.
REQ-011 The module SHALL have port busy, output, 1 bit: high while in BUSY or DONE.

Function
REQ-012 The module SHALL implement exactly three states: IDLE, BUSY, DONE.
REQ-013 In IDLE with re or we high at a clock edge, the module SHALL capture addr[MEM_AW-1:0], wdata and op, load the counter with LATENCY-1, and enter BUSY.
REQ-014 When we and re are both high in IDLE, the module SHALL treat the request as a write; re is ignored.
REQ-015 In BUSY, the module SHALL decrement the counter each cycle; at count 0 it SHALL perform the access and enter DONE, giving exactly LATENCY BUSY cycles.
REQ-016 A write SHALL commit the captured wdata to the captured address at the edge leaving BUSY.
REQ-017 A read SHALL load rd_data from the captured address at the edge leaving BUSY.
REQ-018 In DONE, rdy SHALL be 1 for exactly one cycle; then the state SHALL return to IDLE.
REQ-019 rdy timing: a request first seen in IDLE in cycle 0 SHALL give rdy=1 in cycle LATENCY+1.
REQ-020 re, we, addr and wdata SHALL be ignored in BUSY and DONE; only captured values are used.
REQ-021 If the initiator drops re/we mid-BUSY, the access SHALL still complete, with rdy pulsed (no abort).
REQ-022 A request still asserted in the cycle after DONE SHALL be accepted as a new access (minimum one IDLE cycle between accesses).
REQ-023 rd_data SHALL hold its last read value through writes and idle cycles; it changes only on read completion.
REQ-024 A read to an address written by the immediately preceding access SHALL return the new data.
REQ-025 Address bits above MEM_AW-1 SHALL be ignored, aliasing to the lower index.
REQ-026 busy SHALL be 0 in IDLE and 1 in BUSY and DONE.

Reset
REQ-027 With rst high at a clock edge, the state SHALL go to IDLE, rdy=0, busy=0, rd_data=64'h0, counter=0, overriding any other event that cycle.
REQ-028 Reset mid-BUSY SHALL abort the access: no write commit, no rdy, rd_data=0.
REQ-029 Storage array contents SHALL NOT be altered by reset.
REQ-030 The first request SHALL be accepted in the first cycle with rst low.

Verification
REQ-031 Write/readback test: LATENCY=4; write addr 14'h0012, wdata 64'hDEAD_BEEF_0123_4567, held until rdy; then read 14'h0012 -> rdy exactly 5 cycles after each request start; rd_data=64'hDEAD_BEEF_0123_4567 at read rdy.
REQ-032 Simultaneous re/we test: re=we=1, addr 5, wdata 64'h1 -> treated as write; rd_data unchanged; a later read of 5 returns 64'h1.
REQ-033 Reset-abort test: start write 64'hFF to addr 7, assert rst in the 2nd BUSY cycle -> no rdy, busy=0 next cycle; a subsequent read of 7 returns the prior contents, not 64'hFF.
REQ-034 Dropped-request test: read request, re dropped after 1 cycle -> rdy still pulses at cycle LATENCY+1, with valid rd_data.
REQ-035 Back-to-back and LATENCY=1 test: with LATENCY=1 and re held continuously -> rdy pulses every 3 cycles; with MEM_AW=10, addr 14'h0400 aliases to 14'h0000.

Source files
------------

// File: rtl/line_mem_responder.sv
// line_mem_responder: single-port line memory behind a fixed-latency
// request/ready handshake. A request seen in IDLE is captured, held in BUSY
// for LATENCY cycles, completed at the edge leaving BUSY, and acknowledged
// with a one-cycle rdy strobe in DONE.
//
// state | meaning
// IDLE  | waiting for re/we; captures addr, wdata and op when either is high
// BUSY  | counting down the access latency; request inputs are ignored
// DONE  | access complete, rdy high for this single cycle
module line_mem_responder #(
  parameter int LATENCY = 4,
  parameter int MEM_AW  = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [63:0] wdata,
  output logic [63:0] rd_data,
  output logic        rdy,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic              op_wr_q;
  logic              access_now;

  logic [63:0] mem [0:(1 << MEM_AW) - 1];

  // The access happens on the edge that leaves BUSY, i.e. when the count is spent.
  assign access_now = (state == BUSY) && (cnt == 4'd0);

  assign rdy  = (state == DONE);
  assign busy = (state != IDLE);

  // Handshake FSM, latency counter, request capture and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 64'h0;
      op_wr_q <= 1'b0;
      rd_data <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          if (re || we) begin
            addr_q  <= addr[MEM_AW-1:0];
            wdata_q <= wdata;
            op_wr_q <= we;  // write wins when both are requested
            cnt     <= CNT_LOAD;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            if (!op_wr_q) begin
              rd_data <= mem[addr_q];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage keeps its contents through reset; a reset on the commit edge
  // suppresses the write so an aborted access leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && access_now && op_wr_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: a table of single accesses on a default
// instance, hand sequences for reset abort and dropped/changed requests, and
// a LATENCY=1 / MEM_AW=10 instance for back-to-back reads and address aliasing.
module tb_line_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [13:0] addr_a = '0;
  logic        re_a = 1'b0, we_a = 1'b0;
  logic [63:0] wdata_a = '0;
  logic [63:0] rd_data_a;
  logic        rdy_a, busy_a;

  logic [13:0] addr_b = '0;
  logic        re_b = 1'b0, we_b = 1'b0;
  logic [63:0] wdata_b = '0;
  logic [63:0] rd_data_b;
  logic        rdy_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  line_mem_responder #(.LATENCY(4), .MEM_AW(14)) dut_a (
    .clk(clk), .rst(rst), .addr(addr_a), .re(re_a), .we(we_a),
    .wdata(wdata_a), .rd_data(rd_data_a), .rdy(rdy_a), .busy(busy_a)
  );

  line_mem_responder #(.LATENCY(1), .MEM_AW(10)) dut_b (
    .clk(clk), .rst(rst), .addr(addr_b), .re(re_b), .we(we_b),
    .wdata(wdata_b), .rd_data(rd_data_b), .rdy(rdy_b), .busy(busy_b)
  );

  typedef struct {
    logic        re;
    logic        we;
    logic [13:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge in the cycle the request should be seen (cycle 0).
  // Holds the request until rdy, returning the cycle number of rdy and
  // whether busy stayed high throughout.
  task automatic access_a(input logic r, input logic w, input logic [13:0] a,
                          input logic [63:0] d, output int n, output logic busy_ok);
    re_a = r; we_a = w; addr_a = a; wdata_a = d;
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!busy_a) busy_ok = 1'b0;
    end while (!rdy_a && n < 40);
    re_a = 1'b0; we_a = 1'b0;
  endtask

  initial begin
    int n;
    logic bok;

    tbl[0] = '{re:1'b0, we:1'b1, addr:14'h0012, wdata:64'hDEAD_BEEF_0123_4567, exp_rd:64'h0};
    tbl[1] = '{re:1'b1, we:1'b0, addr:14'h0012, wdata:64'h0,                  exp_rd:64'hDEAD_BEEF_0123_4567};
    tbl[2] = '{re:1'b1, we:1'b1, addr:14'h0005, wdata:64'h1,                  exp_rd:64'hDEAD_BEEF_0123_4567};
    tbl[3] = '{re:1'b1, we:1'b0, addr:14'h0005, wdata:64'h0,                  exp_rd:64'h1};
    tbl[4] = '{re:1'b0, we:1'b1, addr:14'h0007, wdata:64'h77,                 exp_rd:64'h1};
    tbl[5] = '{re:1'b0, we:1'b1, addr:14'h3FFF, wdata:64'hAAAA_5555_AAAA_5555, exp_rd:64'h1};
    tbl[6] = '{re:1'b1, we:1'b0, addr:14'h3FFF, wdata:64'h0,                  exp_rd:64'hAAAA_5555_AAAA_5555};
    tbl[7] = '{re:1'b1, we:1'b0, addr:14'h0007, wdata:64'h0,                  exp_rd:64'h77};

    repeat (3) @(negedge clk);
    chk("reset_rdy", rdy_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_rd_data", rd_data_a, 64'h0);

    // First request is presented in the first cycle with rst low.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      access_a(tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].wdata, n, bok);
      chk($sformatf("tbl%0d_latency", i), n, 5);
      chk($sformatf("tbl%0d_busy", i), bok, 1'b1);
      chk($sformatf("tbl%0d_rd_data", i), rd_data_a, tbl[i].exp_rd);
    end

    // rd_data holds and busy is low through idle cycles.
    repeat (3) @(negedge clk);
    chk("idle_busy", busy_a, 1'b0);
    chk("idle_rd_hold", rd_data_a, 64'h77);

    // Reset in the second BUSY cycle of a write aborts it.
    we_a = 1'b1; addr_a = 14'h0007; wdata_a = 64'hFF;
    @(negedge clk);
    chk("abort_busy1", busy_a, 1'b1);
    @(negedge clk);
    chk("abort_busy2_rdy", rdy_a, 1'b0);
    rst = 1'b1; we_a = 1'b0;
    @(negedge clk);
    chk("abort_rdy", rdy_a, 1'b0);
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_rd_data", rd_data_a, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_post_rdy", rdy_a, 1'b0);
    access_a(1'b1, 1'b0, 14'h0007, 64'h0, n, bok);
    chk("abort_read_latency", n, 5);
    chk("abort_read_old", rd_data_a, 64'h77);

    // Read with re dropped after one cycle and inputs scrambled mid-BUSY.
    @(negedge clk);
    re_a = 1'b1; addr_a = 14'h0012;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin re_a = 1'b0; we_a = 1'b1; addr_a = 14'h0005; wdata_a = 64'hBAD; end
      if (n == 3) we_a = 1'b0;
    end while (!rdy_a && n < 40);
    chk("drop_latency", n, 5);
    chk("drop_rd_data", rd_data_a, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk);
    access_a(1'b1, 1'b0, 14'h0005, 64'h0, n, bok);
    chk("drop_no_write", rd_data_a, 64'h1);

    // LATENCY=1, MEM_AW=10: write line 0, then read 14'h0400 held continuously.
    @(negedge clk);
    we_b = 1'b1; addr_b = 14'h0000; wdata_b = 64'h1234_5678_9ABC_DEF0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_b && n < 20);
    chk("b_write_latency", n, 2);
    we_b = 1'b0;
    @(negedge clk);
    chk("b_idle_busy", busy_b, 1'b0);
    re_b = 1'b1; addr_b = 14'h0400;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("b_rdy_cycle%0d", k), rdy_b, (k % 3 == 2));
      if (k % 3 == 2) chk($sformatf("b_alias_rd%0d", k), rd_data_b, 64'h1234_5678_9ABC_DEF0);
    end
    re_b = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
